mem_arbiter: RTL

Arbiter between the icache and dcache miss paths and the single memory port. Each cycle it selects one request (dcache writeback, dcache load miss, or icache miss) and drives the memory command bus. It records which cache owns every outstanding memory tag and steers returned tags to that owner. Its per-cache accept and tag outputs feed the caches' MSHRs (`mem_req_accepted`, `current_req_tag`, `mem_data_tag`), and its writeback port drains dirty dcache evictions.

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_tag_owner_table.sv | 52 +++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: bus widths, command encoding,
// request packets and the per-tag owner encoding.
package mem_arbiter_pkg;

    localparam int NUM_MEM_TAGS = 15;
    localparam int MEM_TAG_W    = $clog2(NUM_MEM_TAGS + 1);

    typedef logic [31:0]          ADDR;
    typedef logic [63:0]          MEM_BLOCK;
    typedef logic [MEM_TAG_W-1:0] MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic valid;
        ADDR  addr;
    } I_ADDR_PACKET;

    typedef enum logic [1:0] {
        FREE   = 2'h0,
        ICACHE = 2'h1,
        DCACHE = 2'h2
    } OWNER_T;

    typedef enum logic [1:0] {
        GRANT_NONE   = 2'h0,
        GRANT_WB     = 2'h1,
        GRANT_DCACHE = 2'h2,
        GRANT_ICACHE = 2'h3
    } GRANT_T;

    function automatic ADDR block_align(input ADDR addr);
        return addr & ~ADDR'(7);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; master is the arbiter's
// view, slave is the view of the caches and memory around it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    I_ADDR_PACKET icache_req_addr;
    logic         icache_req_accepted;
    MEM_TAG       icache_current_req_tag;
    MEM_TAG       icache_mem_data_tag;

    I_ADDR_PACKET dcache_req_addr;
    logic         dcache_req_accepted;
    MEM_TAG       dcache_current_req_tag;
    MEM_TAG       dcache_mem_data_tag;

    logic         dcache_wb_valid;
    ADDR          dcache_wb_addr;
    MEM_BLOCK     dcache_wb_data;
    logic         dcache_wb_accepted;

    MEM_COMMAND   proc2mem_command;
    ADDR          proc2mem_addr;
    MEM_BLOCK     proc2mem_data;
    MEM_TAG       mem2proc_transaction_tag;
    MEM_TAG       mem2proc_data_tag;

    logic         stray_tag;

    modport master (
        input  icache_req_addr,
        output icache_req_accepted, icache_current_req_tag, icache_mem_data_tag,
        input  dcache_req_addr,
        output dcache_req_accepted, dcache_current_req_tag, dcache_mem_data_tag,
        input  dcache_wb_valid, dcache_wb_addr, dcache_wb_data,
        output dcache_wb_accepted,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data_tag,
        output stray_tag
    );

    modport slave (
        output icache_req_addr,
        input  icache_req_accepted, icache_current_req_tag, icache_mem_data_tag,
        output dcache_req_addr,
        input  dcache_req_accepted, dcache_current_req_tag, dcache_mem_data_tag,
        output dcache_wb_valid, dcache_wb_addr, dcache_wb_data,
        input  dcache_wb_accepted,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data_tag,
        input  stray_tag
    );

endinterface

// File: rtl/mem_tag_owner_table.sv
// Registered record of which cache owns each outstanding memory tag.
// Entry 0 is never allocated because tag 0 means "no tag".
module mem_tag_owner_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   alloc_en,
    input  MEM_TAG alloc_tag,
    input  OWNER_T alloc_owner,
    input  logic   free_en,
    input  MEM_TAG free_tag,
    input  MEM_TAG lookup_tag,
    output OWNER_T lookup_owner
);

    localparam MEM_TAG MAX_TAG = MEM_TAG'(NUM_TAGS);

    OWNER_T owner_q [NUM_TAGS+1];
    OWNER_T owner_d [NUM_TAGS+1];

    // Allocation is applied after the free so a tag recycled in the same cycle keeps its new owner.
    always_comb begin
        owner_d = owner_q;
        if (free_en && free_tag != '0 && free_tag <= MAX_TAG) begin
            owner_d[free_tag] = FREE;
        end
        if (alloc_en && alloc_tag != '0 && alloc_tag <= MAX_TAG) begin
            owner_d[alloc_tag] = alloc_owner;
        end
    end

    always_comb begin
        lookup_owner = FREE;
        if (lookup_tag != '0 && lookup_tag <= MAX_TAG) begin
            lookup_owner = owner_q[lookup_tag];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                owner_q[i] <= FREE;
            end
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates writebacks, dcache load misses and icache misses onto the single
// memory port, and routes returning data tags back to the cache that issued them.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int NUM_TAGS     = NUM_MEM_TAGS
) (
    input  logic clock,
    input  logic reset,
    mem_arbiter_if.master bus
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    GRANT_T grant;
    logic   mem_accepted;
    logic   icache_accepted;
    logic   dcache_accepted;
    logic   wb_accepted;
    logic   alloc_en;
    OWNER_T alloc_owner;
    logic   free_en;
    OWNER_T return_owner;

    // Outputs are held quiet while reset is asserted, regardless of inputs.
    always_comb begin
        grant = GRANT_NONE;
        if (!reset) begin
            if (bus.icache_req_addr.valid && starve_cnt_q == CNT_MAX) begin
                grant = GRANT_ICACHE;
            end else if (bus.dcache_wb_valid) begin
                grant = GRANT_WB;
            end else if (bus.dcache_req_addr.valid) begin
                grant = GRANT_DCACHE;
            end else if (bus.icache_req_addr.valid) begin
                grant = GRANT_ICACHE;
            end
        end
    end

    always_comb begin
        bus.proc2mem_command = MEM_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        case (grant)
            GRANT_WB: begin
                bus.proc2mem_command = MEM_STORE;
                bus.proc2mem_addr    = block_align(bus.dcache_wb_addr);
                bus.proc2mem_data    = bus.dcache_wb_data;
            end
            GRANT_DCACHE: begin
                bus.proc2mem_command = MEM_LOAD;
                bus.proc2mem_addr    = block_align(bus.dcache_req_addr.addr);
            end
            GRANT_ICACHE: begin
                bus.proc2mem_command = MEM_LOAD;
                bus.proc2mem_addr    = block_align(bus.icache_req_addr.addr);
            end
            default: begin
            end
        endcase
    end

    // A zero transaction tag means memory refused the command; the requester retries next cycle.
    always_comb begin
        mem_accepted    = bus.mem2proc_transaction_tag != '0;
        icache_accepted = (grant == GRANT_ICACHE) && mem_accepted;
        dcache_accepted = (grant == GRANT_DCACHE) && mem_accepted;
        wb_accepted     = (grant == GRANT_WB)     && mem_accepted;
        alloc_en        = icache_accepted || dcache_accepted;
        alloc_owner     = icache_accepted ? ICACHE : DCACHE;
    end

    always_comb begin
        bus.icache_req_accepted    = icache_accepted;
        bus.dcache_req_accepted    = dcache_accepted;
        bus.dcache_wb_accepted     = wb_accepted;
        bus.icache_current_req_tag = icache_accepted ? bus.mem2proc_transaction_tag : '0;
        bus.dcache_current_req_tag = dcache_accepted ? bus.mem2proc_transaction_tag : '0;
    end

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) owner_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_tag    (bus.mem2proc_transaction_tag),
        .alloc_owner  (alloc_owner),
        .free_en      (free_en),
        .free_tag     (bus.mem2proc_data_tag),
        .lookup_tag   (bus.mem2proc_data_tag),
        .lookup_owner (return_owner)
    );

    always_comb begin
        free_en                 = !reset && bus.mem2proc_data_tag != '0;
        bus.icache_mem_data_tag = '0;
        bus.dcache_mem_data_tag = '0;
        bus.stray_tag           = 1'b0;
        if (free_en) begin
            case (return_owner)
                ICACHE:  bus.icache_mem_data_tag = bus.mem2proc_data_tag;
                DCACHE:  bus.dcache_mem_data_tag = bus.mem2proc_data_tag;
                default: bus.stray_tag           = 1'b1;
            endcase
        end
    end

    // Counts cycles the icache has waited; saturates so the forced grant stays armed until taken.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.icache_req_addr.valid || icache_accepted) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
